// File: rtl/pulse_repeater_pkg.sv
// Shared types and constants for the multi-channel pulse repeater.
package pulse_repeater_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    LOW,
    HOLD
  } rep_state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_FREERUN = 1'b1;
  localparam int   MIN_PERIOD   = 2;

endpackage

// File: rtl/pulse_repeater_ch.sv
// One repeater channel: FSM, shadow config, period/burst counters, overrun.
// PULSE_REPEATER_TRIG_EDGE_EN selects a rising-edge trigger.
module pulse_repeater_ch
  import pulse_repeater_pkg::*;
#(
  parameter int CNT_W   = 10,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               trig_raw,
  input  logic               cfg_enable,
  input  logic               cfg_mode,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               clear_overrun,
  output logic               enable,
  output logic               busy,
  output logic               overrun
);

  rep_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BURST_W-1:0] bcnt, bcnt_n;
  logic [CNT_W-1:0]   sh_period, sh_width;
  logic [BURST_W-1:0] sh_burst;
  logic [CNT_W-1:0]   norm_period, norm_width;
  logic [BURST_W-1:0] norm_burst;
  logic               latch;
  logic               fire;
  logic               overrun_n;

`ifdef PULSE_REPEATER_TRIG_EDGE_EN
  logic trig_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) trig_q <= 1'b0;
    else         trig_q <= trig_raw;
  end

  assign fire = trig_raw & ~trig_q & cfg_enable;
`else
  assign fire = trig_raw & cfg_enable;
`endif

  // Width is clamped so every pulse slot keeps at least one low cycle.
  always_comb begin
    norm_period = cfg_period;
    if (cfg_period < CNT_W'(MIN_PERIOD))
      norm_period = CNT_W'(MIN_PERIOD);
    norm_width = cfg_width;
    if (cfg_width == '0)
      norm_width = CNT_W'(1);
    if (norm_width >= norm_period)
      norm_width = norm_period - CNT_W'(1);
    norm_burst = cfg_burst;
    if (cfg_burst == '0)
      norm_burst = BURST_W'(1);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bcnt_n  = bcnt;
    latch   = 1'b0;
    if (!cfg_enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      bcnt_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            latch   = 1'b1;
            state_n = PULSE;
            cnt_n   = CNT_W'(1);
            bcnt_n  = BURST_W'(1);
          end
        end
        PULSE: begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == sh_width)
            state_n = LOW;
        end
        LOW: begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == sh_period) begin
            cnt_n = CNT_W'(1);
            if (bcnt < sh_burst) begin
              bcnt_n  = bcnt + BURST_W'(1);
              state_n = PULSE;
            end else begin
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == sh_period) begin
            if (cfg_mode == MODE_FREERUN) begin
              latch   = 1'b1;
              state_n = PULSE;
              cnt_n   = CNT_W'(1);
              bcnt_n  = BURST_W'(1);
            end else begin
              state_n = IDLE;
              cnt_n   = '0;
              bcnt_n  = '0;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    overrun_n = overrun;
    if (clear_overrun)
      overrun_n = 1'b0;
    if (fire && state != IDLE)
      overrun_n = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      bcnt      <= '0;
      sh_period <= '0;
      sh_width  <= '0;
      sh_burst  <= '0;
      enable    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bcnt    <= bcnt_n;
      enable  <= (state_n == PULSE);
      overrun <= overrun_n;
      if (latch) begin
        sh_period <= norm_period;
        sh_width  <= norm_width;
        sh_burst  <= norm_burst;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/pulse_repeater_mc.sv
// Multi-channel trigger-to-pulse repeater; ready is a global trigger.
// PULSE_REPEATER_TRIG_EDGE_EN selects a rising-edge trigger.
module pulse_repeater_mc
  import pulse_repeater_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 10,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_CH-1:0]  trig_in,
  input  logic               ready,
  input  logic [NUM_CH-1:0]  cfg_enable,
  input  logic               cfg_mode,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [NUM_CH-1:0]  clear_overrun,
  output logic [NUM_CH-1:0]  enable,
  output logic [NUM_CH-1:0]  busy,
  output logic [NUM_CH-1:0]  overrun
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pulse_repeater_ch #(
      .CNT_W  (CNT_W),
      .BURST_W(BURST_W)
    ) u_ch (
      .clk          (clk),
      .resetn       (resetn),
      .trig_raw     (trig_in[c] | ready),
      .cfg_enable   (cfg_enable[c]),
      .cfg_mode     (cfg_mode),
      .cfg_period   (cfg_period),
      .cfg_width    (cfg_width),
      .cfg_burst    (cfg_burst),
      .clear_overrun(clear_overrun[c]),
      .enable       (enable[c]),
      .busy         (busy[c]),
      .overrun      (overrun[c])
    );
  end

endmodule

// File: tb/tb_pulse_repeater_mc.sv
// Directed bench for pulse_repeater_mc; expectations follow
// PULSE_REPEATER_TRIG_EDGE_EN where the two trigger modes differ.
module tb_pulse_repeater_mc;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] trig_in;
  logic       ready;
  logic [3:0] cfg_enable;
  logic       cfg_mode;
  logic [9:0] cfg_period;
  logic [9:0] cfg_width;
  logic [7:0] cfg_burst;
  logic [3:0] clear_overrun;
  logic [3:0] enable;
  logic [3:0] busy;
  logic [3:0] overrun;

  int checks = 0;
  int errors = 0;
  logic [63:0] en_hist, bsy_hist;
  logic        others;
  int          en_cnt, bsy_cnt, en3_cnt;
  logic        exp_ovr;
  int          exp_pulses;
  logic [3:0]  exp_ovr_all;

  pulse_repeater_mc dut (
    .clk          (clk),
    .resetn       (resetn),
    .trig_in      (trig_in),
    .ready        (ready),
    .cfg_enable   (cfg_enable),
    .cfg_mode     (cfg_mode),
    .cfg_period   (cfg_period),
    .cfg_width    (cfg_width),
    .cfg_burst    (cfg_burst),
    .clear_overrun(clear_overrun),
    .enable       (enable),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit i of the histories holds channel 0 after the i-th edge.
  task automatic run(input int n);
    en_hist  = '0;
    bsy_hist = '0;
    for (int i = 1; i <= n; i++) begin
      tick();
      en_hist[i]  = enable[0];
      bsy_hist[i] = busy[0];
      others = others | (|enable[3:1]) | (|busy[3:1]);
      if (i == 1) trig_in = '0;
    end
  endtask

  initial begin
    resetn        = 1'b0;
    trig_in       = '0;
    ready         = 1'b0;
    cfg_enable    = 4'b0001;
    cfg_mode      = 1'b0;
    cfg_period    = '0;
    cfg_width     = '0;
    cfg_burst     = '0;
    clear_overrun = '0;
    others        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enable", 64'(enable), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_overrun", 64'(overrun), 64'h0);
    resetn = 1'b1;
    tick();

    cfg_period = 10'd4;
    cfg_width  = 10'd1;
    cfg_burst  = 8'd1;
    trig_in    = 4'b0001;
    run(10);
    chk("basic_en", en_hist, 64'h2);
    chk("basic_busy", bsy_hist, 64'h1FE);
    chk("basic_other_ch", 64'(others), 64'h0);

    cfg_period = 10'd5;
    cfg_width  = 10'd2;
    cfg_burst  = 8'd3;
    trig_in    = 4'b0001;
    run(22);
    chk("burst_en", en_hist, 64'h18C6);
    chk("burst_busy", bsy_hist, 64'h1FFFFE);

    cfg_period = 10'd0;
    cfg_width  = 10'd7;
    cfg_burst  = 8'd0;
    trig_in    = 4'b0001;
    run(6);
    chk("clamp_en", en_hist, 64'h2);
    chk("clamp_busy", bsy_hist, 64'h1E);

    cfg_period = 10'd8;
    cfg_width  = 10'd2;
    cfg_burst  = 8'd2;
    trig_in    = 4'b0001;
    tick();
    trig_in    = '0;
    tick();
    tick();
    trig_in    = 4'b0001;
    tick();
    trig_in    = '0;
    chk("ovr_set", 64'(overrun[0]), 64'h1);
    en_cnt  = 0;
    bsy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      en_cnt  += int'(enable[0]);
      bsy_cnt += int'(busy[0]);
    end
    chk("ovr_en_cnt", 64'(en_cnt), 64'd2);
    chk("ovr_busy_cnt", 64'(bsy_cnt), 64'd20);
    chk("ovr_idle", 64'(busy[0]), 64'h0);
    chk("ovr_sticky", 64'(overrun[0]), 64'h1);
    trig_in       = 4'b0001;
    tick();
    trig_in       = '0;
    tick();
    trig_in       = 4'b0001;
    clear_overrun = 4'b0001;
    tick();
    trig_in       = '0;
    chk("ovr_set_wins", 64'(overrun[0]), 64'h1);
    tick();
    clear_overrun = '0;
    chk("ovr_cleared", 64'(overrun[0]), 64'h0);
    repeat (30) tick();

    cfg_mode   = 1'b1;
    cfg_period = 10'd4;
    cfg_width  = 10'd1;
    cfg_burst  = 8'd1;
    trig_in    = 4'b0001;
    run(24);
    chk("free_en", en_hist, 64'h20202);
    chk("free_busy", bsy_hist, 64'h1FFFFFE);
    tick();
    chk("free_pulse25", 64'(enable[0]), 64'h1);
    cfg_enable = '0;
    tick();
    chk("abort_en", 64'(enable[0]), 64'h0);
    chk("abort_busy", 64'(busy[0]), 64'h0);
    cfg_enable = 4'b0001;
    cfg_mode   = 1'b0;

    cfg_period = 10'd5;
    cfg_width  = 10'd2;
    cfg_burst  = 8'd3;
    trig_in    = 4'b0001;
    tick();
    tick();
    trig_in    = '0;
`ifdef PULSE_REPEATER_TRIG_EDGE_EN
    exp_ovr = 1'b0;
`else
    exp_ovr = 1'b1;
`endif
    chk("mid_en", 64'(enable[0]), 64'h1);
    chk("mid_ovr", 64'(overrun[0]), 64'(exp_ovr));
    #2 resetn = 1'b0;
    #1;
    chk("async_en", 64'(enable), 64'h0);
    chk("async_busy", 64'(busy), 64'h0);
    chk("async_ovr", 64'(overrun), 64'h0);
    #2 resetn = 1'b1;
    tick();

    cfg_enable = 4'hF;
    cfg_period = 10'd4;
    cfg_width  = 10'd1;
    cfg_burst  = 8'd1;
    ready      = 1'b1;
    en_cnt     = 0;
    en3_cnt    = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      en_cnt  += int'(enable[0]);
      en3_cnt += int'(enable[3]);
    end
    ready = 1'b0;
`ifdef PULSE_REPEATER_TRIG_EDGE_EN
    exp_pulses  = 1;
    exp_ovr_all = 4'h0;
`else
    exp_pulses  = 6;
    exp_ovr_all = 4'hF;
`endif
    chk("held_ch0", 64'(en_cnt), 64'(exp_pulses));
    chk("held_ch3", 64'(en3_cnt), 64'(exp_pulses));
    chk("held_ovr", 64'(overrun), 64'(exp_ovr_all));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
